// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core front end.
package npc_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   typedef enum logic [2:0] {
      NONE        = 3'd0,
      TRAP        = 3'd1,
      MRET        = 3'd2,
      BR          = 3'd3,
      BR_MISALIGN = 3'd4
   } redir_cause_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake between the PC generator (master) and instruction fetch (slave).
interface pc_gen_if;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_ready;

   modport master (output pc, output pc_valid, input pc_ready);
   modport slave  (input pc, input pc_valid, output pc_ready);
endinterface

// File: rtl/pc_redirect_arb.sv
// Prioritises trap, mret and branch requests; halt is resolved by the caller.
module pc_redirect_arb
   import npc_pkg::*;
(
   input  logic         br_taken,
   input  logic [31:0]  br_target,
   input  logic         trap_req,
   input  logic [31:0]  trap_vec,
   input  logic         mret_req,
   input  logic [31:0]  mepc,
   output redir_cause_e cause,
   output logic [31:0]  target
);

   // Fixed-priority redirect selection.
   always_comb begin
      cause  = NONE;
      target = 32'h0000_0000;
      if (trap_req) begin
         cause  = TRAP;
         target = word_align(trap_vec);
      end else if (mret_req) begin
         cause  = MRET;
         target = word_align(mepc);
      end else if (br_taken) begin
         if (br_target[1:0] == 2'b00) begin
            cause  = BR;
            target = br_target;
         end else begin
            // Misaligned branch targets vector to the trap handler.
            cause  = BR_MISALIGN;
            target = word_align(trap_vec);
         end
      end else begin
         cause  = NONE;
         target = 32'h0000_0000;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: owns the architectural PC and drives fetch requests.
module pc_gen
   import npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst,
   pc_gen_if.master         fetch,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             trap_req,
   input  logic [31:0]      trap_vec,
   input  logic             mret_req,
   input  logic [31:0]      mepc,
   input  logic             halt_req,
   output logic             pc_flush,
   output logic             misalign_err,
   output logic [31:0]      misalign_addr,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt
);

   pc_state_e        state_d, state_q;
   logic [31:0]      pc_d, pc_q;
   logic             pc_valid_d, pc_valid_q;
   logic             pc_flush_d, pc_flush_q;
   logic             misalign_err_d, misalign_err_q;
   logic [31:0]      misalign_addr_d, misalign_addr_q;
   logic             halted_d, halted_q;
   logic [CNT_W-1:0] fetch_cnt_d, fetch_cnt_q;
   redir_cause_e     cause;
   logic [31:0]      redir_target;

   pc_redirect_arb u_arb (
      .br_taken  (br_taken),
      .br_target (br_target),
      .trap_req  (trap_req),
      .trap_vec  (trap_vec),
      .mret_req  (mret_req),
      .mepc      (mepc),
      .cause     (cause),
      .target    (redir_target)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      pc_valid_d      = pc_valid_q;
      pc_flush_d      = 1'b0;
      misalign_err_d  = 1'b0;
      misalign_addr_d = misalign_addr_q;
      halted_d        = halted_q;
      fetch_cnt_d     = fetch_cnt_q;
      case (state_q)
         BOOT: begin
            state_d    = RUN;
            pc_valid_d = 1'b1;
         end
         RUN: begin
            if (halt_req) begin
               state_d    = HALT;
               pc_valid_d = 1'b0;
               halted_d   = 1'b1;
            end else if (cause != NONE) begin
               pc_d       = redir_target;
               pc_valid_d = 1'b1;
               pc_flush_d = 1'b1;
               if (cause == BR_MISALIGN) begin
                  misalign_err_d  = 1'b1;
                  misalign_addr_d = br_target;
               end else begin
                  misalign_err_d  = 1'b0;
               end
            end else if (pc_valid_q && fetch.pc_ready) begin
               pc_d        = pc_q + 32'd4;
               pc_valid_d  = 1'b1;
               fetch_cnt_d = fetch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               pc_valid_d = 1'b1;
            end
         end
         HALT: begin
            pc_valid_d = 1'b0;
            halted_d   = 1'b1;
         end
         default: begin
            state_d    = BOOT;
            pc_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= BOOT;
         pc_q            <= RESET_PC;
         pc_valid_q      <= 1'b0;
         pc_flush_q      <= 1'b0;
         misalign_err_q  <= 1'b0;
         misalign_addr_q <= 32'h0000_0000;
         halted_q        <= 1'b0;
         fetch_cnt_q     <= {CNT_W{1'b0}};
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         pc_valid_q      <= pc_valid_d;
         pc_flush_q      <= pc_flush_d;
         misalign_err_q  <= misalign_err_d;
         misalign_addr_q <= misalign_addr_d;
         halted_q        <= halted_d;
         fetch_cnt_q     <= fetch_cnt_d;
      end
   end

   assign fetch.pc       = pc_q;
   assign fetch.pc_valid = pc_valid_q;
   assign pc_flush       = pc_flush_q;
   assign misalign_err   = misalign_err_q;
   assign misalign_addr  = misalign_addr_q;
   assign halted         = halted_q;
   assign fetch_cnt      = fetch_cnt_q;

endmodule
